jmb_window_ctrl: RTL and testbench

JMB_WINDOW_CTRL -- requirements
Module: jmb_window_ctrl

---
 rtl/jmb_window_ctrl_if.sv | 27 ++
 rtl/jmb_window_ctrl.sv | 104 ++++++++++
 tb/tb_jmb_window_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/jmb_window_ctrl_if.sv
// Pixel-in / window-out handshake bundle for the 9x9 window controller.
// The master side is the controller; the slave side is the surrounding datapath.
interface jmb_window_ctrl_if #(
  parameter int image_width  = 512,
  parameter int image_height = 512
);
  localparam int row_w = $clog2(image_height);
  localparam int col_w = $clog2(image_width);

  logic             in_valid;
  logic             in_ready;
  logic             win_enable;
  logic             win_valid;
  logic             out_ready;
  logic [row_w-1:0] win_row;
  logic [col_w-1:0] win_col;

  modport master (
    input  in_valid, out_ready,
    output in_ready, win_enable, win_valid, win_row, win_col
  );

  modport slave (
    output in_valid, out_ready,
    input  in_ready, win_enable, win_valid, win_row, win_col
  );
endinterface

// File: rtl/jmb_window_ctrl.sv
// Raster-scan controller for a 9x9 sliding-window datapath: counts accepted
// pixels, drives the window shift enable, and flags when the window registers
// hold a window lying fully inside the image together with its centre position.
module jmb_window_ctrl #(
  parameter int image_width  = 512,
  parameter int image_height = 512,
  parameter int win_size     = 9
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  jmb_window_ctrl_if.master bus
);

  localparam int row_w = $clog2(image_height);
  localparam int col_w = $clog2(image_width);
  localparam int span  = win_size - 1;
  localparam int half  = win_size / 2;

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [row_w-1:0] row;
  logic [col_w-1:0] col;
  logic             win_valid_q;
  logic [row_w-1:0] win_row_q;
  logic [col_w-1:0] win_col_q;
  logic             in_ready;
  logic             accept;
  logic             col_last;
  logic             row_last;
  logic             qualify;
  logic             drain_exit;

  // Handshake decode and next-state selection.
  always_comb begin
    in_ready   = reset_n && (state == FILL || state == RUN) &&
                 (!win_valid_q || bus.out_ready);
    accept     = in_ready && bus.in_valid;
    col_last   = (col == col_w'(image_width - 1));
    row_last   = (row == row_w'(image_height - 1));
    qualify    = accept && (row >= row_w'(span)) && (col >= col_w'(span));
    drain_exit = (state == DRAIN) && (!win_valid_q || bus.out_ready);
    state_nxt  = state;
    unique case (state)
      IDLE:  if (start) state_nxt = FILL;
      FILL:  if (accept && col_last && row == row_w'(span - 1)) state_nxt = RUN;
      RUN:   if (accept && col_last && row_last) state_nxt = DRAIN;
      DRAIN: if (drain_exit) state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      row <= '0;
      col <= '0;
    end else if (state == IDLE && start) begin
      row <= '0;
      col <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + row_w'(1);
      end else begin
        col <= col + col_w'(1);
      end
    end
  end

  // Window-valid flag and centre coordinates, loaded on the shifting edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
    end else if (drain_exit) begin
      win_valid_q <= 1'b0;
    end else if (qualify) begin
      win_valid_q <= 1'b1;
      win_row_q   <= row - row_w'(half);
      win_col_q   <= col - col_w'(half);
    end else if (win_valid_q && bus.out_ready) begin
      win_valid_q <= 1'b0;
    end
  end

  assign busy           = reset_n && (state != IDLE);
  assign frame_done     = reset_n && drain_exit;
  assign bus.in_ready   = in_ready;
  assign bus.win_enable = accept;
  assign bus.win_valid  = win_valid_q;
  assign bus.win_row    = win_row_q;
  assign bus.win_col    = win_col_q;

endmodule

// File: tb/tb_jmb_window_ctrl.sv
// Directed bench for jmb_window_ctrl on a 16x12 image (32 windows per frame).
module tb_jmb_window_ctrl;

  logic clock;
  logic reset_n;
  logic start;
  logic busy;
  logic frame_done;

  int checks   = 0;
  int failures = 0;

  jmb_window_ctrl_if #(.image_width(16), .image_height(12)) bus ();

  jmb_window_ctrl #(
    .image_width (16),
    .image_height(12),
    .win_size    (9)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .busy      (busy),
    .frame_done(frame_done),
    .bus       (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observation of each cycle's handshake, taken mid-cycle.
  int         cyc_cnt       = 0;
  int         acc_cnt       = 0;
  int         last_acc_cyc  = 0;
  int         fd_cnt        = 0;
  int         fd_cyc        = 0;
  int         first_win_acc = -1;
  int         en_mis        = 0;
  logic [7:0] winq[$];

  always @(negedge clock) begin
    cyc_cnt++;
    if (reset_n) begin
      if (bus.win_valid && first_win_acc < 0) first_win_acc = acc_cnt;
      if (frame_done) begin fd_cnt++; fd_cyc = cyc_cnt; end
      if (bus.win_enable) begin acc_cnt++; last_acc_cyc = cyc_cnt; end
      if (bus.win_enable !== (bus.in_valid & bus.in_ready)) en_mis++;
      if (bus.win_valid && bus.out_ready) winq.push_back({bus.win_row, bus.win_col});
    end
  end

  task automatic clear_mon();
    acc_cnt = 0; last_acc_cyc = 0; fd_cnt = 0; fd_cyc = 0;
    first_win_acc = -1; en_mis = 0; winq.delete();
  endtask

  task automatic cyc(input logic st, input logic iv, input logic ordy);
    @(posedge clock); #1;
    start = st; bus.in_valid = iv; bus.out_ready = ordy;
    @(negedge clock); #1;
  endtask

  task automatic finish_frame(output bit timed_out);
    int n = 0;
    while (fd_cnt == 0 && n < 600) begin cyc(1'b0, 1'b1, 1'b1); n++; end
    timed_out = (fd_cnt == 0);
    cyc(1'b0, 1'b0, 1'b1);
  endtask

  // Number of consumed windows that break the expected raster order.
  function automatic int seq_errors();
    int bad = 0;
    logic [7:0] expv;
    foreach (winq[k]) begin
      expv = {4'(4 + k / 8), 4'(4 + k % 8)};
      if (winq[k] !== expv) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; start = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); #1;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.win_enable !== 1'b0) begin failures++; $display("FAIL rst_win_enable got=%0b exp=0", bus.win_enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%0b exp=0", frame_done); end
    checks++; if (bus.win_valid !== 1'b0) begin failures++; $display("FAIL rst_win_valid got=%0b exp=0", bus.win_valid); end
    checks++; if ({bus.win_row, bus.win_col} !== 8'h00) begin failures++; $display("FAIL rst_coords got=%0d,%0d exp=0,0", bus.win_row, bus.win_col); end
    @(posedge clock); #1;
    reset_n = 1'b1; start = 1'b0;
    @(negedge clock); #1;
    checks++; if (bus.win_enable !== 1'b0) begin failures++; $display("FAIL idle_in_valid_ignored got=%0b exp=0", bus.win_enable); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_basic();
    bit to;
    clear_mon();
    cyc(1'b1, 1'b1, 1'b1);
    finish_frame(to);
    checks++; if (to) begin failures++; $display("FAIL basic_timeout got=no frame_done exp=frame_done"); end
    checks++; if (first_win_acc != 137) begin failures++; $display("FAIL basic_first_window_accept got=%0d exp=137", first_win_acc); end
    checks++; if (winq.size() == 0 || winq[0] !== 8'h44) begin failures++; $display("FAIL basic_first_coords got=%0h exp=44", winq.size() ? winq[0] : 8'hxx); end
    checks++; if (winq.size() != 32) begin failures++; $display("FAIL basic_window_count got=%0d exp=32", winq.size()); end
    checks++; if (seq_errors() != 0) begin failures++; $display("FAIL basic_sequence got=%0d bad exp=0", seq_errors()); end
    checks++; if (acc_cnt != 192) begin failures++; $display("FAIL basic_accepts got=%0d exp=192", acc_cnt); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL basic_frame_done_count got=%0d exp=1", fd_cnt); end
    checks++; if (fd_cyc != last_acc_cyc + 1) begin failures++; $display("FAIL basic_frame_done_timing got=%0d exp=%0d", fd_cyc, last_acc_cyc + 1); end
    checks++; if (en_mis != 0) begin failures++; $display("FAIL basic_enable_eq_accept got=%0d exp=0", en_mis); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_after got=%0b exp=0", busy); end
  endtask

  task automatic test_stall();
    bit to;
    int n = 0;
    int bad_hs = 0;
    int bad_xy = 0;
    logic [3:0] r0, c0;
    clear_mon();
    cyc(1'b1, 1'b1, 1'b1);
    while (!bus.win_valid && n < 300) begin cyc(1'b0, 1'b1, 1'b1); n++; end
    checks++; if (bus.win_valid !== 1'b1) begin failures++; $display("FAIL stall_no_window got=%0b exp=1", bus.win_valid); end
    r0 = '0; c0 = '0;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, 1'b0);
      if (bus.in_ready !== 1'b0 || bus.win_enable !== 1'b0 || bus.win_valid !== 1'b1) bad_hs++;
      if (i == 0) begin r0 = bus.win_row; c0 = bus.win_col; end
      else if (bus.win_row !== r0 || bus.win_col !== c0) bad_xy++;
    end
    checks++; if ({r0, c0} !== 8'h45) begin failures++; $display("FAIL stall_held_coords got=%0d,%0d exp=4,5", r0, c0); end
    checks++; if (bad_hs != 0) begin failures++; $display("FAIL stall_handshake got=%0d bad cycles exp=0", bad_hs); end
    checks++; if (bad_xy != 0) begin failures++; $display("FAIL stall_coords_stable got=%0d bad cycles exp=0", bad_xy); end
    finish_frame(to);
    checks++; if (to) begin failures++; $display("FAIL stall_timeout got=no frame_done exp=frame_done"); end
    checks++; if (winq.size() != 32) begin failures++; $display("FAIL stall_window_count got=%0d exp=32", winq.size()); end
    checks++; if (seq_errors() != 0) begin failures++; $display("FAIL stall_sequence got=%0d bad exp=0", seq_errors()); end
    checks++; if (acc_cnt != 192) begin failures++; $display("FAIL stall_accepts got=%0d exp=192", acc_cnt); end
  endtask

  task automatic test_random();
    logic [15:0] vpat = 16'hB2E5;
    logic [15:0] opat = 16'hF7BD;
    int n = 0;
    clear_mon();
    cyc(1'b1, 1'b0, 1'b1);
    while (fd_cnt == 0 && n < 1500) begin
      cyc(1'b0, vpat[n % 16], opat[(n * 3) % 16]);
      n++;
    end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL rand_frame_done got=%0d exp=1", fd_cnt); end
    checks++; if (en_mis != 0) begin failures++; $display("FAIL rand_enable_eq_accept got=%0d exp=0", en_mis); end
    checks++; if (acc_cnt != 192) begin failures++; $display("FAIL rand_accepts got=%0d exp=192", acc_cnt); end
    checks++; if (winq.size() != 32) begin failures++; $display("FAIL rand_window_count got=%0d exp=32", winq.size()); end
    checks++; if (seq_errors() != 0) begin failures++; $display("FAIL rand_sequence got=%0d bad exp=0", seq_errors()); end
  endtask

  task automatic test_line_end();
    bit to;
    int n = 0;
    int bad = 0;
    clear_mon();
    cyc(1'b1, 1'b1, 1'b1);
    while (!(bus.win_valid && bus.win_row == 4'd4 && bus.win_col == 4'd11) && n < 300) begin
      cyc(1'b0, 1'b1, 1'b1); n++;
    end
    checks++; if (!(bus.win_valid && bus.win_row == 4'd4 && bus.win_col == 4'd11)) begin failures++; $display("FAIL line_end_window got=%0d,%0d exp=4,11", bus.win_row, bus.win_col); end
    checks++; if (acc_cnt != 145) begin failures++; $display("FAIL line_end_accepts got=%0d exp=145", acc_cnt); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b1);
      if (bus.win_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL line_end_gap got=%0d valid cycles exp=0", bad); end
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (bus.win_valid !== 1'b1 || {bus.win_row, bus.win_col} !== 8'h54) begin failures++; $display("FAIL line_end_next got=%0b %0d,%0d exp=1 5,4", bus.win_valid, bus.win_row, bus.win_col); end
    finish_frame(to);
    checks++; if (to || winq.size() != 32) begin failures++; $display("FAIL line_end_window_count got=%0d exp=32", winq.size()); end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n = 0;
    clear_mon();
    cyc(1'b1, 1'b1, 1'b1);
    while (acc_cnt < 150 && n < 300) begin cyc(1'b0, 1'b1, 1'b1); n++; end
    @(posedge clock); #1;
    reset_n = 1'b0;
    @(negedge clock); #1;
    checks++; if (bus.in_ready !== 1'b0 || bus.win_enable !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_during got=%0b%0b%0b exp=000", bus.in_ready, bus.win_enable, busy); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock); #1;
    checks++; if (bus.win_valid !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got=%0b%0b%0b exp=000", bus.win_valid, frame_done, busy); end
    checks++; if ({bus.win_row, bus.win_col} !== 8'h00) begin failures++; $display("FAIL mid_rst_coords got=%0d,%0d exp=0,0", bus.win_row, bus.win_col); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_needs_start got=%0b exp=0", bus.in_ready); end
    clear_mon();
    cyc(1'b1, 1'b1, 1'b1);
    finish_frame(to);
    checks++; if (to || fd_cnt != 1) begin failures++; $display("FAIL mid_rst_refram_done got=%0d exp=1", fd_cnt); end
    checks++; if (winq.size() != 32 || seq_errors() != 0) begin failures++; $display("FAIL mid_rst_reframe_windows got=%0d bad=%0d exp=32 bad=0", winq.size(), seq_errors()); end
    checks++; if (acc_cnt != 192) begin failures++; $display("FAIL mid_rst_reframe_accepts got=%0d exp=192", acc_cnt); end
  endtask

  task automatic test_start_drain();
    int n = 0;
    int bad = 0;
    clear_mon();
    cyc(1'b1, 1'b1, 1'b1);
    while (acc_cnt < 140 && n < 300) begin cyc(1'b0, 1'b1, 1'b1); n++; end
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL run_start_busy got=%0b exp=1", busy); end
    n = 0;
    while (acc_cnt < 192 && n < 300) begin cyc(1'b0, 1'b1, 1'b1); n++; end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (frame_done !== 1'b0 || busy !== 1'b1 || bus.win_valid !== 1'b1) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL drain_hold got=%0d bad cycles exp=0", bad); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL drain_release got=%0b exp=1", frame_done); end
    cyc(1'b0, 1'b0, 1'b1);
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0 || bus.win_valid !== 1'b0) begin failures++; $display("FAIL drain_exit got=%0b%0b%0b exp=000", frame_done, busy, bus.win_valid); end
    checks++; if (fd_cnt != 1) begin failures++; $display("FAIL drain_pulse_count got=%0d exp=1", fd_cnt); end
    checks++; if (winq.size() != 32 || seq_errors() != 0) begin failures++; $display("FAIL drain_windows got=%0d bad=%0d exp=32 bad=0", winq.size(), seq_errors()); end
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_random();
    test_line_end();
    test_reset_mid();
    test_start_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
